// File: rtl/logic_net_sched.sv
// Scheduled, multi-cycle evaluation of the 5-input/2-output logic network over WIDTH-bit vectors.
// Build option LOGIC_NET_CHAIN_EN chains two logic levels per step (3 steps instead of 6).
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// C1-C6 | one schedule step each (C1-C3 only with LOGIC_NET_CHAIN_EN)
// DONE  | one-cycle done pulse, then back to IDLE
module logic_net_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] p,
  output logic [CNT_W-1:0] jobs
);

`ifdef LOGIC_NET_CHAIN_EN
  typedef enum logic [2:0] {IDLE, C1, C2, C3, DONE} state_t;
  localparam state_t LAST = C3;
`else
  typedef enum logic [2:0] {IDLE, C1, C2, C3, C4, C5, C6, DONE} state_t;
  localparam state_t LAST = C6;
`endif

  state_t state, state_next;

  logic [WIDTH-1:0] ra, rb, rc, rd, re;
  logic [WIDTH-1:0] h, j, k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = C1;
`ifdef LOGIC_NET_CHAIN_EN
      C1:   state_next = C2;
      C2:   state_next = C3;
      C3:   state_next = DONE;
`else
      C1:   state_next = C2;
      C2:   state_next = C3;
      C3:   state_next = C4;
      C4:   state_next = C5;
      C5:   state_next = C6;
      C6:   state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      rc <= '0;
      rd <= '0;
      re <= '0;
    end else if (state == IDLE && start) begin
      ra <= a;
      rb <= b;
      rc <= c;
      rd <= d;
      re <= e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) jobs <= '0;
    else if (state == LAST && jobs != '1) jobs <= jobs + 1'b1;
  end

`ifdef LOGIC_NET_CHAIN_EN
  // Chained levels are combinational within a step; only step boundaries are registered.
  logic [WIDTH-1:0] f_w, g_w, i_w, l_w;
  assign f_w = ra | rb;
  assign g_w = rb & rd;
  assign i_w = rc | h;
  assign l_w = rd & re & k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      j <= '0;
      k <= '0;
      o <= '0;
      p <= '0;
    end else begin
      case (state)
        C1: begin
          h <= f_w | g_w;
          j <= re | f_w | g_w;
        end
        C2: k <= i_w & j;
        C3: begin
          p <= ~k;
          o <= ~l_w;
        end
        default: ;
      endcase
    end
  end
`else
  logic [WIDTH-1:0] f, g, i, l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f <= '0;
      g <= '0;
      h <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      l <= '0;
      o <= '0;
      p <= '0;
    end else begin
      case (state)
        C1: begin
          f <= ra | rb;
          g <= rb & rd;
        end
        C2: begin
          h <= f | g;
          j <= re | f | g;
        end
        C3: i <= rc | h;
        C4: k <= i & j;
        C5: begin
          l <= rd & re & k;
          p <= ~k;
        end
        C6: o <= ~l;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_logic_net_sched.sv
// Bench for logic_net_sched: vector table, random jobs against a network model, held start,
// mid-job reset and counter saturation on a CNT_W=2 instance.
module tb_logic_net_sched;

`ifdef LOGIC_NET_CHAIN_EN
  localparam int LAT = 3;
  localparam int PER = 5;
`else
  localparam int LAT = 6;
  localparam int PER = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic [7:0] a, b, c, d, e;
  logic       busy, done, busy2, done2;
  logic [7:0] o, p, o2, p2, jobs;
  logic [1:0] jobs2;

  int total = 0;
  int bad = 0;
  int jobs_exp = 0;

  always #5 clk = ~clk;

  logic_net_sched #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .o(o), .p(p), .jobs(jobs));

  logic_net_sched #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy2), .done(done2), .o(o2), .p(p2), .jobs(jobs2));

  typedef struct {
    logic [7:0] a, b, c, d, e, eo, ep;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Network evaluated per bit from its boolean definition.
  function automatic void model(input logic [7:0] ia, ib, ic, id, ie,
                                output logic [7:0] mo, mp);
    for (int n = 0; n < 8; n++) begin
      bit f, g, h, i, j, k, l;
      f = ia[n] || ib[n];
      g = ib[n] && id[n];
      h = f || g;
      i = ic[n] || h;
      j = ie[n] || f || g;
      k = i && j;
      l = id[n] && ie[n] && k;
      mo[n] = !l;
      mp[n] = !k;
    end
  endfunction

  task automatic scramble();
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    d = 8'($urandom);
    e = 8'($urandom);
  endtask

  task automatic run_job(input logic [7:0] ia, ib, ic, id, ie, output int lat);
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; e = ie;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t tbl[6];
    int lat;
    logic [7:0] mo, mp, ra, rb, rc, rd, re;
    logic [7:0] qo[$], qp[$];
    int qt[$];
    int next_acc;

    tbl[0] = '{8'h0F, 8'h33, 8'h00, 8'h55, 8'hFF, 8'hEA, 8'hC0};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    tbl[3] = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F};
    tbl[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    tbl[5] = '{8'h00, 8'h0F, 8'h00, 8'h3C, 8'h3C, 8'hF3, 8'hF0};

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_o", o, 0);
    check("rst_p", p, 0);
    check("rst_jobs", jobs, 0);
    check("rst_jobs2", jobs2, 0);

    for (int v = 0; v < 6; v++) begin
      run_job(tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].d, tbl[v].e, lat);
      jobs_exp++;
      check("tbl_latency", lat, LAT);
      check("tbl_o", o, tbl[v].eo);
      check("tbl_p", p, tbl[v].ep);
      check("tbl_jobs", jobs, jobs_exp);
      if (v == 2) begin
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          check("stable_o", o, 8'h00);
          check("stable_p", p, 8'h00);
          check("stable_done", done, 0);
        end
      end
    end

    for (int r = 0; r < 20; r++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      rd = 8'($urandom); re = 8'($urandom);
      model(ra, rb, rc, rd, re, mo, mp);
      run_job(ra, rb, rc, rd, re, lat);
      jobs_exp++;
      check("rnd_latency", lat, LAT);
      check("rnd_o", o, mo);
      check("rnd_p", p, mp);
      check("rnd_jobs", jobs, jobs_exp);
    end

    // Held start with operands changing every cycle; only accept-edge operands matter.
    @(negedge clk);
    next_acc = 0;
    for (int t = 0; t < 45; t++) begin
      start = (t < 32);
      scramble();
      if (t < 32 && t == next_acc) begin
        model(a, b, c, d, e, mo, mp);
        qo.push_back(mo);
        qp.push_back(mp);
        qt.push_back(t + LAT);
        next_acc += PER;
      end
      @(posedge clk);
      @(negedge clk);
      if (qt.size() > 0 && qt[0] == t) begin
        check("hold_done", done, 1);
        jobs_exp++;
        check("hold_o", o, qo.pop_front());
        check("hold_p", p, qp.pop_front());
        check("hold_jobs", jobs, jobs_exp);
        void'(qt.pop_front());
      end else begin
        check("hold_done", done, 0);
      end
    end
    start = 1'b0;

    // Reset in the third schedule step of a running job.
    @(negedge clk);
    a = 8'h0F; b = 8'h33; c = 8'h00; d = 8'h55; e = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_o", o, 0);
    check("abort_p", p, 0);
    check("abort_jobs", jobs, 0);
    @(negedge clk);
    rst = 1'b0;
    jobs_exp = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    check("abort_jobs_after", jobs, 0);
    run_job(8'h0F, 8'h33, 8'h00, 8'h55, 8'hFF, lat);
    check("restart_latency", lat, LAT);
    check("restart_o", o, 8'hEA);
    check("restart_p", p, 8'hC0);
    check("restart_jobs", jobs, 1);

    // Saturating counter on the narrow instance.
    a = 8'h0F; b = 8'h33; c = 8'h00; d = 8'h55; e = 8'hFF;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      lat = -1;
      for (int k = 0; k <= 20; k++) begin
        @(negedge clk);
        if (done2) begin
          lat = k;
          break;
        end
      end
      check("sat_latency", lat, LAT);
      check("sat_jobs", jobs2, (n < 3) ? n : 3);
      check("sat_o", o2, 8'hEA);
      check("sat_p", p2, 8'hC0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
